inventory_ctrl: RTL and testbench

INVENTORY_CTRL -- requirements
Module: inventory_ctrl

---
 rtl/inventory_ctrl_if.sv | 9 +
 rtl/inventory_ctrl.sv | 85 ++++++++
 tb/tb_inventory_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/inventory_ctrl_if.sv
// inventory_ctrl_if: memory bus between the stock controller and its stock memory
// master (controller): drives mem_addr, mem_set, mem_value; reads mem_rdata
// slave (memory): returns mem_rdata one cycle after mem_addr, writes on mem_set
interface inventory_ctrl_if;
  logic [7:0] mem_addr, mem_rdata, mem_value;
  logic mem_set;
  modport master(output mem_addr, mem_set, mem_value, input mem_rdata);
  modport slave(input mem_addr, mem_set, mem_value, output mem_rdata);
endinterface

// File: rtl/inventory_ctrl.sv
// inventory_ctrl: add/remove stock transactions against an external stock memory
// clk, rst_n (sync, active-low); mode 1=add 0=remove; c_q 1=code 0=quantity on save
// in operand switches; save/submit active-low async pushbuttons; mem memory bus (master)
// out resulting stock; status 00 none 01 ok 10 saturated 11 insufficient; busy; done pulse
module inventory_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             c_q,
  input  logic [7:0]       in,
  input  logic             save,
  input  logic             submit,
  inventory_ctrl_if.master mem,
  output logic [7:0]       out,
  output logic [1:0]       status,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;
  state_t r_state, w_next;
  // [0],[1] synchronizer, [2] previous synchronized level for edge detection
  logic [2:0] r_sv, r_sb;
  // r_vld[1] marks that the synchronizer output holds a real pin sample, so a
  // button held low through reset release is never mistaken for a falling edge
  logic [1:0] r_vld;
  logic [7:0] r_code, r_quant, r_wval, r_out;
  logic [1:0] r_pst, r_status;
  logic r_mode;
  logic w_save_ev, w_sub_ev, w_short;
  logic [8:0] w_sum;
  logic [7:0] w_val;
  logic [1:0] w_st;
  assign w_save_ev = r_sv[2] & ~r_sv[1];
  assign w_sub_ev = r_sb[2] & ~r_sb[1] & ~w_save_ev;
  assign w_sum = {1'b0, mem.mem_rdata} + {1'b0, r_quant};
  assign w_short = ~r_mode & (r_quant > mem.mem_rdata);
  assign w_val = r_mode ? (w_sum[8] ? 8'hff : w_sum[7:0]) : (w_short ? mem.mem_rdata : mem.mem_rdata - r_quant);
  assign w_st = r_mode ? (w_sum[8] ? 2'b10 : 2'b01) : (w_short ? 2'b11 : 2'b01);
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE  ? (w_sub_ev ? READ : IDLE) :
             r_state == READ  ? CALC :
             r_state == CALC  ? (w_short ? DONE : WRITE) :
             r_state == WRITE ? DONE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sv <= 3'b011;
      r_sb <= 3'b011;
      r_vld <= 2'b00;
      r_code <= '0;
      r_quant <= '0;
      r_wval <= '0;
      r_out <= '0;
      r_pst <= '0;
      r_status <= '0;
      r_mode <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sv <= {r_sv[1] & r_vld[1], r_sv[0], save};
      r_sb <= {r_sb[1] & r_vld[1], r_sb[0], submit};
      r_vld <= {r_vld[0], 1'b1};
      if (r_state == IDLE && w_save_ev && c_q) r_code <= in;
      if (r_state == IDLE && w_save_ev && !c_q) r_quant <= in;
      if (r_state == IDLE && w_sub_ev) r_mode <= mode;
      if (r_state == CALC) begin
        r_wval <= w_val;
        r_pst <= w_st;
      end
      if (w_next == DONE) begin
        r_out <= r_state == CALC ? w_val : r_wval;
        r_status <= r_state == CALC ? w_st : r_pst;
      end
    end
  end
  // gating with rst_n keeps a reset asserted during WRITE from committing the write
  assign mem.mem_set = (r_state == WRITE) & rst_n;
  assign mem.mem_addr = r_code;
  assign mem.mem_value = r_wval;
  assign out = r_out;
  assign status = r_status;
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_inventory_ctrl.sv
// tb_inventory_ctrl: randomized self-checking bench for inventory_ctrl
module tb_inventory_ctrl;
  logic clk = 0, rst_n = 0, mode = 0, c_q = 0, save = 1, submit = 1;
  logic [7:0] in = 0;
  logic [7:0] out;
  logic [1:0] status;
  logic busy, done;
  int checks = 0, errors = 0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] m_code = 0, m_quant = 0;
  logic pl_en = 0;
  logic [7:0] pl_a = 0, pl_d = 0;
  inventory_ctrl_if bus();
  inventory_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .c_q(c_q), .in(in), .save(save), .submit(submit),
    .mem(bus.master), .out(out), .status(status), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (pl_en) mem[pl_a] <= pl_d;
    else if (bus.mem_set) mem[bus.mem_addr] <= bus.mem_value;
  end
  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_a = a;
    pl_d = d;
    pl_en = 1;
    cyc();
    pl_en = 0;
    ref_mem[a] = d;
  endtask
  // expected {write happens, status, resulting stock}
  function automatic logic [10:0] model(input logic [7:0] old, input logic [7:0] q, input logic md);
    int s;
    s = int'(old) + int'(q);
    if (md) return {1'b1, (s > 255) ? 2'b10 : 2'b01, (s > 255) ? 8'd255 : 8'(s)};
    if (q > old) return {1'b0, 2'b11, old};
    return {1'b1, 2'b01, 8'(int'(old) - int'(q))};
  endfunction
  task automatic press_save(input logic cq, input logic [7:0] v);
    c_q = cq;
    in = v;
    save = 0;
    repeat (4) cyc();
    save = 1;
    repeat (3) cyc();
    if (cq) m_code = v;
    else m_quant = v;
  endtask
  task automatic do_txn(input logic md, input logic retrig, input logic save_busy);
    logic [10:0] exp;
    int n_set, n_done, set_k, done_k;
    logic [7:0] sa, sv, o, a3;
    logic [1:0] st;
    logic b3;
    exp = model(ref_mem[m_code], m_quant, md);
    n_set = 0; n_done = 0; set_k = 0; done_k = 0; sa = 0; sv = 0; o = 0; st = 0; a3 = 0; b3 = 0;
    mode = md;
    submit = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k == 2) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_before_E: got %0b want 0", busy); end
      end
      if (k == 3) begin b3 = busy; a3 = bus.mem_addr; mode = ~md; end
      if (bus.mem_set) begin n_set++; set_k = k; sa = bus.mem_addr; sv = bus.mem_value; end
      if (done) begin n_done++; done_k = k; o = out; st = status; end
      if (retrig && k == 1) submit = 1;
      if (retrig && k == 2) submit = 0;
      if (save_busy && k == 2) begin c_q = 1; in = ~m_code; save = 0; end
      if (save_busy && k == 5) save = 1;
      if (k == 4) submit = 1;
    end
    checks++;
    if (b3 !== 1'b1 || a3 !== m_code) begin errors++; $display("FAIL read_cycle: busy=%0b addr=%0d want busy=1 addr=%0d", b3, a3, m_code); end
    checks++;
    if (n_done != 1 || done_k != (exp[10] ? 6 : 5)) begin errors++; $display("FAIL done_pulse: count=%0d at=%0d want count=1 at=%0d", n_done, done_k, exp[10] ? 6 : 5); end
    checks++;
    if (o !== exp[7:0] || st !== exp[9:8]) begin errors++; $display("FAIL result: out=%0d status=%b want out=%0d status=%b", o, st, exp[7:0], exp[9:8]); end
    checks++;
    if (out !== exp[7:0] || status !== exp[9:8]) begin errors++; $display("FAIL result_hold: out=%0d status=%b want out=%0d status=%b", out, status, exp[7:0], exp[9:8]); end
    if (exp[10]) begin
      checks++;
      if (n_set != 1 || set_k != 5 || sa !== m_code || sv !== exp[7:0]) begin
        errors++;
        $display("FAIL write: count=%0d at=%0d addr=%0d val=%0d want 1 at 5 addr=%0d val=%0d", n_set, set_k, sa, sv, m_code, exp[7:0]);
      end
      ref_mem[m_code] = exp[7:0];
    end else begin
      checks++;
      if (n_set != 0) begin errors++; $display("FAIL no_write: count=%0d want 0", n_set); end
    end
    checks++;
    if (mem[m_code] !== ref_mem[m_code]) begin errors++; $display("FAIL mem_content: mem[%0d]=%0d want %0d", m_code, mem[m_code], ref_mem[m_code]); end
    checks++;
    if (busy !== 1'b0 || bus.mem_addr !== m_code) begin errors++; $display("FAIL idle_after: busy=%0b addr=%0d want busy=0 addr=%0d", busy, bus.mem_addr, m_code); end
  endtask
  task automatic test_reset;
    checks++;
    if ({out, status, busy, done, bus.mem_set, bus.mem_addr, bus.mem_value} !== 29'd0) begin
      errors++;
      $display("FAIL reset_values: out=%0d st=%b busy=%0b done=%0b set=%0b addr=%0d val=%0d want all 0", out, status, busy, done, bus.mem_set, bus.mem_addr, bus.mem_value);
    end
  endtask
  task automatic test_add;
    poke(5, 20);
    press_save(1, 5);
    press_save(0, 10);
    do_txn(1, 0, 0);
  endtask
  task automatic test_saturate;
    poke(5, 250);
    do_txn(1, 0, 0);
  endtask
  task automatic test_insufficient;
    poke(5, 8);
    do_txn(0, 0, 0);
  endtask
  task automatic test_zero_quant;
    press_save(0, 0);
    do_txn(0, 0, 0);
    do_txn(1, 0, 0);
  endtask
  task automatic test_back_to_back;
    press_save(0, 3);
    do_txn(1, 1, 0);
    do_txn(0, 0, 1);
  endtask
  task automatic test_same_cycle;
    int nb;
    nb = 0;
    c_q = 1;
    in = 42;
    save = 0;
    submit = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (busy) nb++;
      if (k == 4) begin save = 1; submit = 1; end
    end
    m_code = 42;
    checks++;
    if (nb != 0 || bus.mem_addr !== 8'd42) begin errors++; $display("FAIL same_cycle: busy_cycles=%0d addr=%0d want 0 and 42", nb, bus.mem_addr); end
  endtask
  task automatic test_reset_in_write;
    int nb;
    poke(m_code, 100);
    press_save(0, 7);
    mode = 1;
    submit = 0;
    repeat (5) cyc();
    checks++;
    if (bus.mem_set !== 1'b1) begin errors++; $display("FAIL write_reached: set=%0b want 1", bus.mem_set); end
    rst_n = 0;
    #1;
    checks++;
    if (bus.mem_set !== 1'b0) begin errors++; $display("FAIL set_gated: set=%0b want 0", bus.mem_set); end
    cyc();
    test_reset();
    checks++;
    if (mem[m_code] !== ref_mem[m_code]) begin errors++; $display("FAIL mem_untouched: mem[%0d]=%0d want %0d", m_code, mem[m_code], ref_mem[m_code]); end
    m_code = 0;
    m_quant = 0;
    rst_n = 1;
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (busy) nb++;
    end
    checks++;
    if (nb != 0) begin errors++; $display("FAIL held_button: busy_cycles=%0d want 0", nb); end
    submit = 1;
    repeat (3) cyc();
  endtask
  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] c, q;
      c = 8'($urandom_range(0, 255));
      q = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) poke(c, 8'($urandom_range(0, 255)));
      press_save(1, c);
      press_save(0, q);
      do_txn(1'($urandom_range(0, 1)), 0, 0);
    end
  endtask
  initial begin
    repeat (3) cyc();
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom_range(0, 255)));
    rst_n = 1;
    repeat (3) cyc();
    test_reset();
    test_add();
    test_saturate();
    test_insufficient();
    test_zero_quant();
    test_back_to_back();
    test_same_cycle();
    test_reset_in_write();
    test_add();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
